// File: rtl/traffic_light_monitor.sv
// Passive lamp-protocol checker for the traffic light controller: one-hot codes, R->G->Y->R order, dwell times.
// Build option TL_MON_STICKY_ERR_EN makes the error flags sticky until clr_err; otherwise they are 1-cycle pulses.
module traffic_light_monitor #(
    parameter int RED_CYCLES    = 50,
    parameter int GREEN_CYCLES  = 40,
    parameter int YELLOW_CYCLES = 10,
    parameter int DWELL_W       = 16,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             err_code,
    output logic             err_order,
    output logic             err_dwell,
    output logic             err_any,
    output logic [CNT_W-1:0] cycles_done
);

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    state_t               state_q, state_d;
    logic [2:0]           light_q, light_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d, dwell_inc;
    logic [1:0]           phase_q, phase_d;
    logic                 err_code_q, err_code_d;
    logic                 err_order_q, err_order_d;
    logic                 err_dwell_q, err_dwell_d;
    logic                 err_any_q, err_any_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 new_code, new_order, new_dwell;
    logic [1:0]           ph_in, ph_prev;

    // Phase numbering: 1 = red, 2 = green, 3 = yellow, 0 = illegal code.
    function automatic logic [1:0] phase_of(input logic [2:0] code);
        case (code)
            3'b100:  return 2'd1;
            3'b001:  return 2'd2;
            3'b010:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] next_phase(input logic [1:0] p);
        case (p)
            2'd1:    return 2'd2;
            2'd2:    return 2'd3;
            2'd3:    return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [DWELL_W-1:0] req_dwell(input logic [1:0] p);
        case (p)
            2'd1:    return DWELL_W'(RED_CYCLES);
            2'd2:    return DWELL_W'(GREEN_CYCLES);
            2'd3:    return DWELL_W'(YELLOW_CYCLES);
            default: return '0;
        endcase
    endfunction

    function automatic logic [DWELL_W-1:0] wd_limit(input logic [1:0] p);
        case (p)
            2'd1:    return DWELL_W'(RED_CYCLES + 1);
            2'd2:    return DWELL_W'(GREEN_CYCLES + 1);
            2'd3:    return DWELL_W'(YELLOW_CYCLES + 1);
            default: return '0;
        endcase
    endfunction

    assign ph_in     = phase_of(light);
    assign ph_prev   = phase_of(light_q);
    assign dwell_inc = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DWELL_W'(1);

    always_comb begin
        state_d   = state_q;
        light_d   = light;
        dwell_d   = dwell_q;
        phase_d   = ph_in;
        cnt_d     = cnt_q;
        new_code  = 1'b0;
        new_order = 1'b0;
        new_dwell = 1'b0;

        if (ph_in == 2'd0) begin
            // Held illegal code is remembered in light_q so repeats stay quiet.
            new_code = (light != light_q);
            state_d  = ACQUIRE;
            dwell_d  = '0;
        end else if (light == light_q) begin
            dwell_d = dwell_inc;
            if (state_q == LOCKED && dwell_inc == wd_limit(ph_in)) begin
                new_dwell = 1'b1;
            end
        end else begin
            dwell_d = DWELL_W'(1);
            if (ph_prev != 2'd0) begin
                if (ph_in == next_phase(ph_prev)) begin
                    if (state_q == LOCKED) begin
                        // Overlong phases were already reported by the watchdog.
                        new_dwell = (dwell_q < req_dwell(ph_prev));
                        if (ph_prev == 2'd3 && cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    state_d = LOCKED;
                end else if (state_q == LOCKED) begin
                    new_order = 1'b1;
                    state_d   = ACQUIRE;
                end
            end
        end

`ifdef TL_MON_STICKY_ERR_EN
        err_code_d  = new_code  | (err_code_q  & ~clr_err);
        err_order_d = new_order | (err_order_q & ~clr_err);
        err_dwell_d = new_dwell | (err_dwell_q & ~clr_err);
`else
        err_code_d  = new_code;
        err_order_d = new_order;
        err_dwell_d = new_dwell;
`endif
        err_any_d = err_code_d | err_order_d | err_dwell_d;
    end

`ifndef TL_MON_STICKY_ERR_EN
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACQUIRE;
            light_q     <= 3'b000;
            dwell_q     <= '0;
            phase_q     <= 2'd0;
            err_code_q  <= 1'b0;
            err_order_q <= 1'b0;
            err_dwell_q <= 1'b0;
            err_any_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            light_q     <= light_d;
            dwell_q     <= dwell_d;
            phase_q     <= phase_d;
            err_code_q  <= err_code_d;
            err_order_q <= err_order_d;
            err_dwell_q <= err_dwell_d;
            err_any_q   <= err_any_d;
            cnt_q       <= cnt_d;
        end
    end

    assign phase       = phase_q;
    assign locked      = (state_q == LOCKED);
    assign err_code    = err_code_q;
    assign err_order   = err_order_q;
    assign err_dwell   = err_dwell_q;
    assign err_any     = err_any_q;
    assign cycles_done = cnt_q;

endmodule
